// File: rtl/red_pitaya_asg_burst_ch.sv
// Single-channel arbitrary signal generator: table RAM, fractional read pointer, burst FSM, triggers, scale/offset/saturate.
// Optional feature macro: ASG_INTERP_EN (linear interpolation between adjacent samples, latency 7 instead of 5).
module red_pitaya_asg_burst_ch #(
  parameter int DW       = 14,
  parameter int RSZ      = 14,
  parameter int TICK_DIV = 125,
  parameter int DEB_CYC  = 62500
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  input  logic              buf_we_i,
  input  logic [RSZ-1:0]    buf_addr_i,
  input  logic [DW-1:0]     buf_wdata_i,
  output logic [DW-1:0]     buf_rdata_o,
  input  logic              trig_sw_i,
  input  logic              trig_ext_i,
  input  logic [2:0]        trig_src_i,
  output logic              trig_done_o,
  output logic              busy_o,
  output logic [DW-1:0]     dac_o,
  output logic [RSZ-1:0]    buf_rpnt_o,
  input  logic [RSZ+15:0]   set_size_i,
  input  logic [RSZ+15:0]   set_step_i,
  input  logic [RSZ+15:0]   set_ofs_i,
  input  logic              set_wrap_i,
  input  logic              set_rst_i,
  input  logic              set_zero_i,
  input  logic [DW-1:0]     set_amp_i,
  input  logic [DW-1:0]     set_dc_i,
  input  logic [DW-1:0]     set_last_i,
  input  logic [15:0]       set_ncyc_i,
  input  logic [15:0]       set_rnum_i,
  input  logic [31:0]       set_rdly_i,
  output logic [1:0]        state_o
);
  localparam int PW  = RSZ + 16;
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DBW = $clog2(DEB_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DELAY = 2'd2, HOLD = 2'd3} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pnt, pnt_nxt, wpnt;
  logic [PW:0]     npnt;
  logic [15:0]     cyc_cnt, cyc_nxt, rep_cnt, rep_nxt;
  logic [31:0]     dly_cnt, dly_nxt;
  logic [TW-1:0]   tick_cnt, tick_nxt;
  logic            wrap, trig, trig_acc;
  logic [2:0]      ext_sync;
  logic            ext_prev, ext_edge, ext_ok;
  logic [DBW-1:0]  deb_cnt;

  assign busy_o     = (state != IDLE);
  assign state_o    = state;
  assign buf_rpnt_o = pnt[PW-1:16];

  // The debounce window runs independently of the FSM so a bouncing edge can never retrigger.
  always_comb begin
    ext_edge = 1'b0;
    if (trig_src_i == 3'd2)      ext_edge = ext_sync[2] & ~ext_prev;
    else if (trig_src_i == 3'd3) ext_edge = ~ext_sync[2] & ext_prev;
    ext_ok = ext_edge && (deb_cnt == '0);
    trig   = ((trig_src_i == 3'd1) && trig_sw_i) || ext_ok;
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      ext_sync <= '0;
      ext_prev <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      ext_sync <= {ext_sync[1:0], trig_ext_i};
      ext_prev <= ext_sync[2];
      if (ext_ok)              deb_cnt <= DBW'(DEB_CYC);
      else if (deb_cnt != '0)  deb_cnt <= deb_cnt - DBW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    pnt_nxt   = pnt;
    cyc_nxt   = cyc_cnt;
    rep_nxt   = rep_cnt;
    dly_nxt   = dly_cnt;
    tick_nxt  = tick_cnt;
    trig_acc  = 1'b0;
    npnt      = {1'b0, pnt} + {1'b0, set_step_i};
    wrap      = npnt > {1'b0, set_size_i};
    wpnt      = set_wrap_i ? (npnt[PW-1:0] - set_size_i - PW'(1)) : set_ofs_i;
    if (set_rst_i) begin
      state_nxt = IDLE;
      pnt_nxt   = set_ofs_i;
      cyc_nxt   = '0;
      rep_nxt   = '0;
      dly_nxt   = '0;
      tick_nxt  = '0;
    end else begin
      case (state)
        IDLE, HOLD: if (trig) begin
          trig_acc  = 1'b1;
          state_nxt = RUN;
          pnt_nxt   = set_ofs_i;
          cyc_nxt   = set_ncyc_i;
          rep_nxt   = set_rnum_i;
        end
        RUN: if (wrap) begin
          pnt_nxt = wpnt;
          if (cyc_cnt == 16'd1) begin
            cyc_nxt = '0;
            if (rep_cnt == '0) begin
              state_nxt = HOLD;
            end else if (set_rdly_i == '0) begin
              // zero delay: next repetition starts straight away
              rep_nxt = rep_cnt - 16'd1;
              cyc_nxt = set_ncyc_i;
              pnt_nxt = set_ofs_i;
            end else begin
              state_nxt = DELAY;
              dly_nxt   = set_rdly_i;
              tick_nxt  = '0;
            end
          end else if (cyc_cnt != '0) begin
            cyc_nxt = cyc_cnt - 16'd1;
          end
        end else begin
          pnt_nxt = npnt[PW-1:0];
        end
        DELAY: begin
          if (tick_cnt == TW'(TICK_DIV - 1)) begin
            tick_nxt = '0;
            if (dly_cnt <= 32'd1) begin
              state_nxt = RUN;
              dly_nxt   = '0;
              rep_nxt   = rep_cnt - 16'd1;
              cyc_nxt   = set_ncyc_i;
              pnt_nxt   = set_ofs_i;
            end else begin
              dly_nxt = dly_cnt - 32'd1;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state       <= IDLE;
      pnt         <= '0;
      cyc_cnt     <= '0;
      rep_cnt     <= '0;
      dly_cnt     <= '0;
      tick_cnt    <= '0;
      trig_done_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      pnt         <= pnt_nxt;
      cyc_cnt     <= cyc_nxt;
      rep_cnt     <= rep_nxt;
      dly_cnt     <= dly_nxt;
      tick_cnt    <= tick_nxt;
      trig_done_o <= trig_acc;
    end
  end

  logic [DW-1:0]       ram [0:2**RSZ-1];
  logic [RSZ-1:0]      rd_addr;
  logic [DW-1:0]       rd_data, smp, sat;
  logic [2*DW:0]       mult;
  logic [DW+1:0]       sum;

  always_ff @(posedge dac_clk_i) begin
    if (buf_we_i) ram[buf_addr_i] <= buf_wdata_i;
  end

`ifdef ASG_INTERP_EN
  logic [RSZ-1:0]      rd_addr1;
  logic [DW-1:0]       rd_data1, base, interp;
  logic [7:0]          frac_a, frac_b, frac_c;
  logic signed [DW:0]  diff;
  logic signed [DW+9:0] prod;

  assign prod = (DW+10)'(diff) * (DW+10)'($signed({1'b0, frac_c}));
  assign smp  = interp;

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      rd_addr1 <= '0;
      rd_data1 <= '0;
      frac_a   <= '0;
      frac_b   <= '0;
      frac_c   <= '0;
      diff     <= '0;
      base     <= '0;
      interp   <= '0;
    end else begin
      rd_addr1 <= (pnt[PW-1:16] == set_size_i[PW-1:16]) ? '0 : pnt[PW-1:16] + RSZ'(1);
      frac_a   <= pnt[15:8];
      rd_data1 <= ram[rd_addr1];
      frac_b   <= frac_a;
      diff     <= $signed({rd_data1[DW-1], rd_data1}) - $signed({rd_data[DW-1], rd_data});
      base     <= rd_data;
      frac_c   <= frac_b;
      interp   <= base + prod[DW+7:8];
    end
  end
`else
  assign smp = rd_data;
`endif

  // One guard bit above the product slice so mult + dc cannot wrap before saturation.
  always_comb begin
    sat = sum[DW-1:0];
    if ((sum[DW+1] != sum[DW]) || (sum[DW] != sum[DW-1]))
      sat = sum[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      rd_addr     <= '0;
      rd_data     <= '0;
      mult        <= '0;
      sum         <= '0;
      dac_o       <= '0;
      buf_rdata_o <= '0;
    end else begin
      rd_addr     <= pnt[PW-1:16];
      rd_data     <= ram[rd_addr];
      buf_rdata_o <= ram[buf_addr_i];
      mult        <= (2*DW+1)'($signed(smp)) * (2*DW+1)'($signed({1'b0, set_amp_i}));
      sum         <= {mult[2*DW-1], mult[2*DW-1:DW-1]} + {{2{set_dc_i[DW-1]}}, set_dc_i};
      if (set_zero_i)         dac_o <= '0;
      else if (state == HOLD) dac_o <= set_last_i;
      else                    dac_o <= sat;
    end
  end
endmodule
